systolic_writeback: RTL and testbench

- Consumer end of the systolic controller's write-out interface.
- Samples diagonal result wavefronts from the array, keyed by sram_write_enable, matrix_index and data_set, and reassembles them into row-major tiles in a ping-pong buffer.
- Drains each completed tile to the output SRAM one row per cycle, then signals completion back toward the host once the last tile has been written.

---
 rtl/systolic_writeback_if.sv | 39 +++
 rtl/systolic_writeback.sv | 240 ++++++++++++++++++++++++
 tb/tb_systolic_writeback.sv | 366 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_writeback_if.sv
// systolic_writeback_if: write-out bus between the systolic controller and
// the writeback block, plus the writeback's output SRAM port and status.
//   tpu_start, tpu_done         : job start / controller done pulses
//   sram_write_enable           : diagonal sample valid
//   matrix_index, data_set      : diagonal index k and tile number of a sample
//   result_data                 : lane i at [i*DATA_W +: DATA_W]
//   out_wen, out_addr, out_wdata: output SRAM row write
//   wb_done, seq_err, ovf_err   : completion pulse and sticky error flags
// master = controller/host side, slave = writeback block.
interface systolic_writeback_if #(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 7
);
    logic                         tpu_start;
    logic                         sram_write_enable;
    logic [5:0]                   matrix_index;
    logic [1:0]                   data_set;
    logic [ARRAY_SIZE*DATA_W-1:0] result_data;
    logic                         tpu_done;
    logic                         out_wen;
    logic [ADDR_W-1:0]            out_addr;
    logic [ARRAY_SIZE*DATA_W-1:0] out_wdata;
    logic                         wb_done;
    logic                         seq_err;
    logic                         ovf_err;

    modport master (
        output tpu_start, sram_write_enable, matrix_index, data_set,
               result_data, tpu_done,
        input  out_wen, out_addr, out_wdata, wb_done, seq_err, ovf_err
    );

    modport slave (
        input  tpu_start, sram_write_enable, matrix_index, data_set,
               result_data, tpu_done,
        output out_wen, out_addr, out_wdata, wb_done, seq_err, ovf_err
    );
endinterface

// File: rtl/systolic_writeback.sv
// systolic_writeback: collects diagonal result wavefronts from the systolic
// array into row-major tiles held in a ping-pong buffer, drains each finished
// tile to the output SRAM one row per cycle, and pulses wb_done once the
// controller has signalled done and every tile has been written.
// Ports:
//   clk, srstn : clock, synchronous active-low reset
//   bus        : systolic_writeback_if slave (write-out samples in, SRAM
//                row writes / completion / error flags out, all registered)
module systolic_writeback #(
    parameter int unsigned ARRAY_SIZE = 8,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 7
) (
    input  logic                clk,
    input  logic                srstn,
    systolic_writeback_if.slave bus
);

    localparam int unsigned ROW_W    = $clog2(ARRAY_SIZE);
    localparam int unsigned IDX_W    = 6;
    localparam int unsigned LAST_K   = 2 * ARRAY_SIZE - 1;
    localparam int unsigned ROW_BITS = ARRAY_SIZE * DATA_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // Ping-pong tile storage, one packed row per entry
    logic [ROW_BITS-1:0] bank_mem [2][ARRAY_SIZE];

    logic             fill_bank_q;
    logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
    logic             discard_q, discard_d;
    logic [1:0]       cur_tag_q;
    logic [1:0]       tag_q [2];
    logic [1:0]       full_q;

    logic             accept, tag_cap, complete, seq_set, ovf_set;
    logic             k_zero, k_match, k_last, bank_busy;

    state_t           state_q, state_d;
    logic             drain_bank_q, drain_bank_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             emit, emit_bank, release_bank;
    logic [ROW_W-1:0] emit_row;

    logic                out_wen_q;
    logic [ADDR_W-1:0]   out_addr_q;
    logic [ROW_BITS-1:0] out_wdata_q;
    logic                wb_done_q, seq_err_q, ovf_err_q, done_q;
    logic                done_fire;

    assign k_zero    = (bus.matrix_index == '0);
    assign k_match   = (bus.matrix_index == exp_idx_q);
    assign k_last    = (bus.matrix_index == IDX_W'(LAST_K));
    assign bank_busy = full_q[fill_bank_q];

    // Fill sequencing: accept in-order diagonals, restart on k=0, drop the rest
    always_comb begin
        accept    = 1'b0;
        tag_cap   = 1'b0;
        complete  = 1'b0;
        seq_set   = 1'b0;
        ovf_set   = 1'b0;
        exp_idx_d = exp_idx_q;
        discard_d = discard_q;
        if (bus.sram_write_enable) begin
            if (k_zero) begin
                if (!k_match && !discard_q) begin
                    seq_set = 1'b1;
                end
                if (bank_busy) begin
                    // Target bank still holds an undrained tile: skip this whole tile
                    ovf_set   = 1'b1;
                    discard_d = 1'b1;
                    exp_idx_d = '0;
                end else begin
                    accept    = 1'b1;
                    tag_cap   = 1'b1;
                    discard_d = 1'b0;
                    exp_idx_d = IDX_W'(1);
                end
            end else if (!discard_q) begin
                if (k_match) begin
                    accept = 1'b1;
                    if (k_last) begin
                        complete  = 1'b1;
                        exp_idx_d = '0;
                    end else begin
                        exp_idx_d = exp_idx_q + IDX_W'(1);
                    end
                end else begin
                    seq_set = 1'b1;
                end
            end
        end
    end

    // Diagonal scatter: lane i of diagonal k lands at row i, column k-i
    always_ff @(posedge clk) begin
        if (srstn && accept) begin
            for (int i = 0; i < int'(ARRAY_SIZE); i++) begin
                for (int j = 0; j < int'(ARRAY_SIZE); j++) begin
                    if (bus.matrix_index == IDX_W'(i + j)) begin
                        bank_mem[fill_bank_q][i][j*DATA_W +: DATA_W] <=
                            bus.result_data[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    // Fill-side state, bank ownership and sticky error flags
    always_ff @(posedge clk) begin
        if (!srstn) begin
            fill_bank_q <= 1'b0;
            exp_idx_q   <= '0;
            discard_q   <= 1'b0;
            cur_tag_q   <= '0;
            tag_q[0]    <= '0;
            tag_q[1]    <= '0;
            full_q      <= '0;
            seq_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            exp_idx_q <= exp_idx_d;
            discard_q <= discard_d;
            if (tag_cap) begin
                cur_tag_q <= bus.data_set;
            end
            if (release_bank) begin
                full_q[emit_bank] <= 1'b0;
            end
            if (complete) begin
                full_q[fill_bank_q] <= 1'b1;
                tag_q[fill_bank_q]  <= cur_tag_q;
                fill_bank_q         <= ~fill_bank_q;
            end
            if (seq_set) begin
                seq_err_q <= 1'b1;
            end
            if (ovf_set) begin
                ovf_err_q <= 1'b1;
            end
            if (bus.tpu_start) begin
                seq_err_q <= 1'b0;
                ovf_err_q <= 1'b0;
                exp_idx_q <= '0;
                discard_q <= 1'b0;
            end
        end
    end

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q      <= ST_IDLE;
            drain_bank_q <= 1'b0;
            row_q        <= '0;
        end else begin
            state_q      <= state_d;
            drain_bank_q <= drain_bank_d;
            row_q        <= row_d;
        end
    end

    // Drain FSM next state; IDLE emits row 0 directly so a tile starts draining
    // the cycle after it completes
    always_comb begin
        state_d      = state_q;
        drain_bank_d = drain_bank_q;
        row_d        = row_q;
        emit         = 1'b0;
        emit_bank    = drain_bank_q;
        emit_row     = row_q;
        release_bank = 1'b0;
        if (state_q == ST_DRAIN) begin
            emit = 1'b1;
        end else if (full_q != 2'b00) begin
            // With both banks full, the one fill is about to reuse is the older
            emit      = 1'b1;
            emit_bank = (&full_q) ? fill_bank_q : full_q[1];
            emit_row  = '0;
        end
        if (emit) begin
            if (emit_row == ROW_W'(ARRAY_SIZE - 1)) begin
                release_bank = 1'b1;
                row_d        = '0;
                if (full_q[~emit_bank]) begin
                    state_d      = ST_DRAIN;
                    drain_bank_d = ~emit_bank;
                end else begin
                    state_d = ST_IDLE;
                end
            end else begin
                state_d      = ST_DRAIN;
                drain_bank_d = emit_bank;
                row_d        = emit_row + ROW_W'(1);
            end
        end
    end

    assign done_fire = done_q && (full_q == 2'b00) && (state_q == ST_IDLE);

    // Registered SRAM write port and completion pulse
    always_ff @(posedge clk) begin
        if (!srstn) begin
            out_wen_q   <= 1'b0;
            out_addr_q  <= '0;
            out_wdata_q <= '0;
            wb_done_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            out_wen_q <= emit;
            if (emit) begin
                out_addr_q  <= ADDR_W'({tag_q[emit_bank], emit_row});
                out_wdata_q <= bank_mem[emit_bank][emit_row];
            end
            wb_done_q <= done_fire;
            if (done_fire) begin
                done_q <= 1'b0;
            end
            if (bus.tpu_done) begin
                done_q <= 1'b1;
            end
            if (bus.tpu_start) begin
                done_q <= 1'b0;
            end
        end
    end

    assign bus.out_wen   = out_wen_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_wdata = out_wdata_q;
    assign bus.wb_done   = wb_done_q;
    assign bus.seq_err   = seq_err_q;
    assign bus.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_systolic_writeback.sv
// tb_systolic_writeback: directed bench for systolic_writeback at N=8/DATA_W=32
// and N=16/DATA_W=16. Lane i of diagonal k for tile s carries {s,i,k}, so
// output row r column c must carry {s,r,r+c}.
module tb_systolic_writeback;

    localparam int unsigned N8  = 8;
    localparam int unsigned W8  = 32;
    localparam int unsigned N16 = 16;
    localparam int unsigned W16 = 16;
    localparam int unsigned AW  = 7;

    logic clk;
    logic srstn;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    systolic_writeback_if #(.ARRAY_SIZE(N8),  .DATA_W(W8),  .ADDR_W(AW)) bus8 ();
    systolic_writeback_if #(.ARRAY_SIZE(N16), .DATA_W(W16), .ADDR_W(AW)) bus16 ();

    systolic_writeback #(.ARRAY_SIZE(N8), .DATA_W(W8), .ADDR_W(AW)) dut8 (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus8)
    );

    systolic_writeback #(.ARRAY_SIZE(N16), .DATA_W(W16), .ADDR_W(AW)) dut16 (
        .clk   (clk),
        .srstn (srstn),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write logs captured on the falling edge
    logic [AW-1:0]      a8_q[$];
    logic [N8*W8-1:0]   d8_q[$];
    int                 c8_q[$];
    int                 wb8_cnt = 0;
    int                 wb8_cyc = 0;
    logic [AW-1:0]      a16_q[$];
    logic [N16*W16-1:0] d16_q[$];
    int                 c16_q[$];
    int                 wb16_cnt = 0;

    always @(negedge clk) begin
        if (bus8.out_wen === 1'b1) begin
            a8_q.push_back(bus8.out_addr);
            d8_q.push_back(bus8.out_wdata);
            c8_q.push_back(cyc);
        end
        if (bus8.wb_done === 1'b1) begin
            wb8_cnt++;
            wb8_cyc = cyc;
        end
        if (bus16.out_wen === 1'b1) begin
            a16_q.push_back(bus16.out_addr);
            d16_q.push_back(bus16.out_wdata);
            c16_q.push_back(cyc);
        end
        if (bus16.wb_done === 1'b1) begin
            wb16_cnt++;
        end
    end

    function automatic logic [W8-1:0] enc8(int s, int i, int k);
        return {8'd0, 8'(s), 8'(i), 8'(k)};
    endfunction

    function automatic logic [N8*W8-1:0] row8(int s, int r);
        logic [N8*W8-1:0] v;
        for (int c = 0; c < int'(N8); c++) v[c*W8 +: W8] = enc8(s, r, r + c);
        return v;
    endfunction

    function automatic logic [W16-1:0] enc16(int s, int i, int k);
        return 16'((s << 10) | (i << 5) | k);
    endfunction

    function automatic logic [N16*W16-1:0] row16(int s, int r);
        logic [N16*W16-1:0] v;
        for (int c = 0; c < int'(N16); c++) v[c*W16 +: W16] = enc16(s, r, r + c);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input int k, input int s);
        logic [N8*W8-1:0] v;
        for (int i = 0; i < int'(N8); i++) v[i*W8 +: W8] = enc8(s, i, k);
        bus8.sram_write_enable = 1'b1;
        bus8.matrix_index      = 6'(k);
        bus8.data_set          = 2'(s);
        bus8.result_data       = v;
    endtask

    task automatic send_tile8(input int s, input int gap_at, input int gap_len, output int t_last);
        for (int k = 0; k < 2 * int'(N8); k++) begin
            if (k == gap_at) begin
                bus8.sram_write_enable = 1'b0;
                repeat (gap_len) tick();
            end
            drive8(k, s);
            tick();
        end
        bus8.sram_write_enable = 1'b0;
        t_last = cyc;
    endtask

    task automatic start8();
        bus8.tpu_start = 1'b1;
        tick();
        bus8.tpu_start = 1'b0;
    endtask

    task automatic clear_log8();
        a8_q.delete();
        d8_q.delete();
        c8_q.delete();
        wb8_cnt = 0;
        wb8_cyc = 0;
    endtask

    task automatic test_reset();
        srstn = 1'b0;
        bus8.tpu_start = 1'b0;  bus8.sram_write_enable = 1'b0;  bus8.tpu_done = 1'b0;
        bus8.matrix_index = '0; bus8.data_set = '0;             bus8.result_data = '0;
        bus16.tpu_start = 1'b0; bus16.sram_write_enable = 1'b0; bus16.tpu_done = 1'b0;
        bus16.matrix_index = '0; bus16.data_set = '0;           bus16.result_data = '0;
        repeat (3) tick();
        checks++; if (bus8.out_wen !== 1'b0) begin errors++; $display("FAIL reset_out_wen: got %b want 0", bus8.out_wen); end
        checks++; if (bus8.out_addr !== '0) begin errors++; $display("FAIL reset_out_addr: got %0d want 0", bus8.out_addr); end
        checks++; if (bus8.out_wdata !== '0) begin errors++; $display("FAIL reset_out_wdata: got %h want 0", bus8.out_wdata); end
        checks++; if (bus8.wb_done !== 1'b0) begin errors++; $display("FAIL reset_wb_done: got %b want 0", bus8.wb_done); end
        checks++; if (bus8.seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b want 0", bus8.seq_err); end
        checks++; if (bus8.ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf_err: got %b want 0", bus8.ovf_err); end
        checks++; if (bus16.out_wen !== 1'b0) begin errors++; $display("FAIL reset_out_wen16: got %b want 0", bus16.out_wen); end
        srstn = 1'b1;
        tick();
    endtask

    // tpu_done with nothing pending: wb_done one cycle later, for one cycle
    task automatic test_done_idle();
        clear_log8();
        bus8.tpu_done = 1'b1;
        tick();
        bus8.tpu_done = 1'b0;
        checks++; if (bus8.wb_done !== 1'b0) begin errors++; $display("FAIL done_idle_early: got %b want 0", bus8.wb_done); end
        tick();
        checks++; if (bus8.wb_done !== 1'b1) begin errors++; $display("FAIL done_idle_pulse: got %b want 1", bus8.wb_done); end
        tick();
        checks++; if (bus8.wb_done !== 1'b0) begin errors++; $display("FAIL done_idle_clear: got %b want 0", bus8.wb_done); end
    endtask

    // Tiles 0 and 1 back to back, then tpu_done: 16 rows at addr 0..15
    task automatic test_nominal();
        int t0, t1, n;
        start8();
        clear_log8();
        send_tile8(0, 99, 0, t0);
        send_tile8(1, 99, 0, t1);
        bus8.tpu_done = 1'b1;
        tick();
        bus8.tpu_done = 1'b0;
        n = 0;
        while (wb8_cnt == 0 && n < 40) begin tick(); n++; end
        repeat (5) tick();
        checks++; if (a8_q.size() != 16) begin errors++; $display("FAIL nominal_count: got %0d writes want 16", a8_q.size()); end
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (w >= a8_q.size()) begin
                errors++; $display("FAIL nominal_row%0d: missing write", w);
            end else if (a8_q[w] !== AW'(w) || d8_q[w] !== row8(w / 8, w % 8)) begin
                errors++; $display("FAIL nominal_row%0d: got addr %0d data %h want addr %0d data %h",
                                   w, a8_q[w], d8_q[w], w, row8(w / 8, w % 8));
            end
        end
        if (c8_q.size() == 16) begin
            checks++; if (c8_q[0] != t0 + 1) begin errors++; $display("FAIL nominal_latency: got cycle %0d want %0d", c8_q[0], t0 + 1); end
            checks++; if (c8_q[15] != t1 + 8) begin errors++; $display("FAIL nominal_last_row: got cycle %0d want %0d", c8_q[15], t1 + 8); end
            checks++; if (wb8_cyc != t1 + 9) begin errors++; $display("FAIL nominal_wb_cycle: got %0d want %0d", wb8_cyc, t1 + 9); end
        end
        checks++; if (wb8_cnt != 1) begin errors++; $display("FAIL nominal_wb_count: got %0d want 1", wb8_cnt); end
        checks++; if (bus8.seq_err !== 1'b0 || bus8.ovf_err !== 1'b0) begin
            errors++; $display("FAIL nominal_flags: got seq %b ovf %b want 0 0", bus8.seq_err, bus8.ovf_err); end
    endtask

    // Tile 3 fills bank 1 while tile 2 drains from bank 0
    task automatic test_back_to_back();
        int t0, t1;
        start8();
        clear_log8();
        send_tile8(2, 99, 0, t0);
        send_tile8(3, 99, 0, t1);
        repeat (12) tick();
        checks++; if (a8_q.size() != 16) begin errors++; $display("FAIL overlap_count: got %0d writes want 16", a8_q.size()); end
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (w >= a8_q.size()) begin
                errors++; $display("FAIL overlap_row%0d: missing write", w);
            end else if (a8_q[w] !== AW'(16 + w) || d8_q[w] !== row8(2 + w / 8, w % 8) ||
                         c8_q[w] != ((w < 8) ? t0 : t1 - 8) + 1 + w) begin
                errors++; $display("FAIL overlap_row%0d: got addr %0d cycle %0d data %h want addr %0d cycle %0d data %h",
                                   w, a8_q[w], c8_q[w], d8_q[w], 16 + w,
                                   ((w < 8) ? t0 : t1 - 8) + 1 + w, row8(2 + w / 8, w % 8));
            end
        end
        checks++; if (bus8.seq_err !== 1'b0 || bus8.ovf_err !== 1'b0) begin
            errors++; $display("FAIL overlap_flags: got seq %b ovf %b want 0 0", bus8.seq_err, bus8.ovf_err); end
        checks++; if (wb8_cnt != 0) begin errors++; $display("FAIL overlap_no_wb: got %0d pulses want 0", wb8_cnt); end
    endtask

    // Five idle cycles between k=7 and k=8 must not change the result
    task automatic test_idle_gap();
        int t;
        start8();
        clear_log8();
        send_tile8(0, 8, 5, t);
        repeat (12) tick();
        checks++; if (a8_q.size() != 8) begin errors++; $display("FAIL gap_count: got %0d writes want 8", a8_q.size()); end
        for (int w = 0; w < 8; w++) begin
            checks++;
            if (w >= a8_q.size()) begin
                errors++; $display("FAIL gap_row%0d: missing write", w);
            end else if (a8_q[w] !== AW'(w) || d8_q[w] !== row8(0, w) || c8_q[w] != t + 1 + w) begin
                errors++; $display("FAIL gap_row%0d: got addr %0d cycle %0d data %h want addr %0d cycle %0d data %h",
                                   w, a8_q[w], c8_q[w], d8_q[w], w, t + 1 + w, row8(0, w));
            end
        end
    endtask

    // k jumps 3 -> 5, then a clean tile restarting at k=0
    task automatic test_seq_err();
        int t;
        start8();
        clear_log8();
        for (int k = 0; k < 4; k++) begin drive8(k, 0); tick(); end
        drive8(5, 0);
        tick();
        bus8.sram_write_enable = 1'b0;
        checks++; if (bus8.seq_err !== 1'b1) begin errors++; $display("FAIL seq_set: got %b want 1", bus8.seq_err); end
        checks++; if (bus8.ovf_err !== 1'b0) begin errors++; $display("FAIL seq_ovf: got %b want 0", bus8.ovf_err); end
        drive8(6, 0);
        tick();
        bus8.sram_write_enable = 1'b0;
        repeat (3) tick();
        checks++; if (a8_q.size() != 0) begin errors++; $display("FAIL seq_dropped: got %0d writes want 0", a8_q.size()); end
        send_tile8(1, 99, 0, t);
        repeat (12) tick();
        checks++; if (a8_q.size() != 8) begin errors++; $display("FAIL seq_count: got %0d writes want 8", a8_q.size()); end
        for (int w = 0; w < 8; w++) begin
            checks++;
            if (w >= a8_q.size()) begin
                errors++; $display("FAIL seq_row%0d: missing write", w);
            end else if (a8_q[w] !== AW'(8 + w) || d8_q[w] !== row8(1, w)) begin
                errors++; $display("FAIL seq_row%0d: got addr %0d data %h want addr %0d data %h",
                                   w, a8_q[w], d8_q[w], 8 + w, row8(1, w));
            end
        end
        checks++; if (bus8.seq_err !== 1'b1) begin errors++; $display("FAIL seq_sticky: got %b want 1", bus8.seq_err); end
        start8();
        checks++; if (bus8.seq_err !== 1'b0) begin errors++; $display("FAIL seq_clear: got %b want 0", bus8.seq_err); end
    endtask

    // Reset right after row 3 of a drain, with a done request pending
    task automatic test_reset_mid();
        int t, n;
        start8();
        clear_log8();
        send_tile8(1, 99, 0, t);
        bus8.tpu_done = 1'b1;
        tick();
        bus8.tpu_done = 1'b0;
        n = 0;
        while (!(bus8.out_wen === 1'b1 && bus8.out_addr === AW'(11)) && n < 20) begin tick(); n++; end
        checks++; if (n >= 20) begin errors++; $display("FAIL mid_row3_seen: got timeout want addr 11 write"); end
        srstn = 1'b0;
        tick();
        checks++; if (bus8.out_wen !== 1'b0) begin errors++; $display("FAIL mid_out_wen: got %b want 0", bus8.out_wen); end
        checks++; if (bus8.seq_err !== 1'b0 || bus8.ovf_err !== 1'b0 || bus8.wb_done !== 1'b0) begin
            errors++; $display("FAIL mid_flags: got seq %b ovf %b wb %b want 0 0 0", bus8.seq_err, bus8.ovf_err, bus8.wb_done); end
        srstn = 1'b1;
        repeat (10) tick();
        checks++; if (a8_q.size() != 4) begin errors++; $display("FAIL mid_partial: got %0d writes want 4", a8_q.size()); end
        checks++; if (wb8_cnt != 0) begin errors++; $display("FAIL mid_no_wb: got %0d pulses want 0", wb8_cnt); end
        start8();
        clear_log8();
        send_tile8(2, 99, 0, t);
        repeat (12) tick();
        checks++; if (a8_q.size() != 8) begin errors++; $display("FAIL mid_clean_count: got %0d writes want 8", a8_q.size()); end
        for (int w = 0; w < 8; w++) begin
            checks++;
            if (w >= a8_q.size()) begin
                errors++; $display("FAIL mid_clean_row%0d: missing write", w);
            end else if (a8_q[w] !== AW'(16 + w) || d8_q[w] !== row8(2, w)) begin
                errors++; $display("FAIL mid_clean_row%0d: got addr %0d data %h want addr %0d data %h",
                                   w, a8_q[w], d8_q[w], 16 + w, row8(2, w));
            end
        end
    endtask

    // N=16, DATA_W=16: tile 2 lands at addr 32..47
    task automatic test_n16();
        int t, n;
        logic [N16*W16-1:0] v;
        a16_q.delete();
        d16_q.delete();
        c16_q.delete();
        wb16_cnt = 0;
        bus16.tpu_start = 1'b1;
        tick();
        bus16.tpu_start = 1'b0;
        for (int k = 0; k < 2 * int'(N16); k++) begin
            for (int i = 0; i < int'(N16); i++) v[i*W16 +: W16] = enc16(2, i, k);
            bus16.sram_write_enable = 1'b1;
            bus16.matrix_index      = 6'(k);
            bus16.data_set          = 2'd2;
            bus16.result_data       = v;
            tick();
        end
        bus16.sram_write_enable = 1'b0;
        t = cyc;
        bus16.tpu_done = 1'b1;
        tick();
        bus16.tpu_done = 1'b0;
        n = 0;
        while (wb16_cnt == 0 && n < 40) begin tick(); n++; end
        repeat (3) tick();
        checks++; if (a16_q.size() != 16) begin errors++; $display("FAIL n16_count: got %0d writes want 16", a16_q.size()); end
        for (int w = 0; w < 16; w++) begin
            checks++;
            if (w >= a16_q.size()) begin
                errors++; $display("FAIL n16_row%0d: missing write", w);
            end else if (a16_q[w] !== AW'(32 + w) || d16_q[w] !== row16(2, w) || c16_q[w] != t + 1 + w) begin
                errors++; $display("FAIL n16_row%0d: got addr %0d cycle %0d data %h want addr %0d cycle %0d data %h",
                                   w, a16_q[w], c16_q[w], d16_q[w], 32 + w, t + 1 + w, row16(2, w));
            end
        end
        checks++; if (wb16_cnt != 1) begin errors++; $display("FAIL n16_wb_count: got %0d want 1", wb16_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_done_idle();
        test_nominal();
        test_back_to_back();
        test_idle_gap();
        test_seq_err();
        test_reset_mid();
        test_n16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
